// File: rtl/riscv_wb_pkg.sv
// Shared types for the register-file writeback front end.
package riscv_wb_pkg;

    localparam int unsigned WB_ADDR_W = 6;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned NUM_REGS  = 2 ** WB_ADDR_W;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/riscv_wb_fifo.sv
// Synchronous FIFO of writeback requests; head is presented straight from storage.
module riscv_wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  wb_req_t                      din_i,
    input  logic                         pop_i,
    output wb_req_t                      dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_req_t            mem_q [DEPTH];
    wb_req_t            mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is datapath only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Regfile write front end: ALU results to port A, round-robin long-latency results via FIFO to port B.
module riscv_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
    parameter int unsigned DATA_WIDTH = WB_DATA_W,
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]                 alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]                 alu_wdata_i,
    input  logic [NUM_SRC-1:0]                    src_valid_i,
    output logic [NUM_SRC-1:0]                    src_ready_o,
    input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]    src_waddr_i,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]    src_wdata_i,
    output logic [ADDR_WIDTH-1:0]                 waddr_a_o,
    output logic [DATA_WIDTH-1:0]                 wdata_a_o,
    output logic                                  we_a_o,
    output logic [ADDR_WIDTH-1:0]                 waddr_b_o,
    output logic [DATA_WIDTH-1:0]                 wdata_b_o,
    output logic                                  we_b_o,
    output logic [2**ADDR_WIDTH-1:0]              busy_o,
    output logic                                  wb_empty_o
);

    localparam int unsigned REGS  = 2 ** ADDR_WIDTH;
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [SRC_W-1:0]   rr_q, rr_d;
    logic [SRC_W-1:0]   gnt_idx;
    logic               any_valid;
    logic               push, pop, collision;
    wb_req_t            push_req, head;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   cnt_q [REGS];
    logic [CNT_W-1:0]   cnt_d [REGS];
    logic               inc, dec;

    // Port A is a straight pass-through; writes to x0 are suppressed.
    assign waddr_a_o = alu_waddr_i;
    assign wdata_a_o = alu_wdata_i;
    assign we_a_o    = alu_valid_i && (alu_waddr_i != '0);

    // First valid source at or after the round-robin pointer wins.
    always_comb begin
        gnt_idx   = rr_q;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            int unsigned sel;
            sel = (int'(rr_q) + k) % NUM_SRC;
            if (!any_valid && src_valid_i[sel]) begin
                any_valid = 1'b1;
                gnt_idx   = SRC_W'(sel);
            end
        end
    end

    always_comb begin
        push          = any_valid && !fifo_full && !rst;
        push_req.addr = src_waddr_i[gnt_idx];
        push_req.data = src_wdata_i[gnt_idx];
        src_ready_o   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_ready_o[i] = push && (gnt_idx == SRC_W'(i));
        end
        rr_d = rr_q;
        if (push) begin
            rr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    riscv_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_req),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Head drains every cycle; a same-cycle ALU write to the same register is younger and wins.
    assign pop        = (fifo_count != '0);
    assign collision  = we_a_o && (head.addr == alu_waddr_i);
    assign we_b_o     = !fifo_empty && (head.addr != '0) && !collision;
    assign waddr_b_o  = head.addr;
    assign wdata_b_o  = head.data;
    assign wb_empty_o = fifo_empty;

    // Per-register outstanding-result counters; x0 is never tracked.
    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        for (int unsigned r = 0; r < REGS; r++) begin
            inc      = push && (r != 0) && (push_req.addr == ADDR_WIDTH'(r));
            dec      = pop  && (r != 0) && (head.addr == ADDR_WIDTH'(r));
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            busy_o[r] = (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
